fp_add_arb: RTL and testbench
=============================

# fp_add_arb

Two-requester round-robin arbiter that time-shares one combinational 13-bit float adder core (1-bit sign, 4-bit exponent, 8-bit fraction) between two independent clients. It sits between the two requesting datapaths and the shared adder. It accepts at most one operand pair per cycle via valid/ready handshakes and returns a registered, ID-tagged result through a single-entry output stage with backpressure.

## Interface
- PRIO_FIRST, default 0: requester that wins the first tie after reset (0 or 1).
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  2  bit i: requester i presents an operand pair
- req_ready  out  2  bit i: requester i's pair is accepted this cycle (one-hot or zero)
- opa0, opb0  in  13 each  requester 0 operands, packed {sign, exp[3:0], frac[7:0]}
- opa1, opb1  in  13 each  requester 1 operands, same packing
- res_valid  out  1  result register holds a valid sum
- res_ready  in  1  downstream consumes result this cycle
- res  out  13  packed sum {sign, exp, frac}
- res_id  out  1  requester the result belongs to
- op_count  out  16  number of accepted requests, wraps

## Operation
- Output slot free when !res_valid || res_ready; arbitration happens only in slot-free cycles; otherwise req_ready = 2'b00.
- Grant: single valid requester is granted. Both valid: grant the one not granted last (last_gnt register). No requests: no grant, last_gnt unchanged.
- last_gnt reset value = ~PRIO_FIRST, so PRIO_FIRST wins the first tie.
- req_ready is combinational from req_valid, last_gnt, res_valid, res_ready, reset. Requesters must not make req_valid depend on req_ready. Operands must stay stable while valid && !ready (bench asserts this).
- Granted operand pair is muxed into the single adder core. Core output is registered into res on the grant edge, with res_id = granted index and res_valid = 1.
- Adder core semantics, to be matched by the bench golden model:
  - order operands by {exp, frac}; on equality the second operand counts as larger;
  - shift the smaller fraction right by the exponent difference;
  - add if signs are equal, else subtract;
  - carry out: exp+1 and fraction = sum[8:1];
  - otherwise normalise left by the leading-zero count. If that count exceeds the exponent, the result is exp 0, frac 0;
  - sign = sign of the larger operand.
- Slot free with no grant: res_valid clears on the consume edge. res/res_id hold their last value (don't-care).
- Output held: res, res_id, res_valid stable while res_valid && !res_ready.
- op_count increments by 1 on every accepted request and wraps 16'hFFFF -> 0.
- Reset mid-operation: a pending result is dropped with no res_valid pulse. A request presented in the reset cycle is not accepted (req_ready forced 0).

## Timing
- Reset values: res_valid 0, res 0, res_id 0, req_ready 0, op_count 0, last_gnt ~PRIO_FIRST.
- Latency: request accepted at edge N -> res_valid high after edge N.
- Throughput: one result per cycle while res_ready stays high. Accept and consume happen in the same cycle (pass-through replacement, no bubble).
- Both requesters continuously valid with res_ready high: grants strictly alternate 0,1,0,1… (PRIO_FIRST=0).
- res_ready low: zero grants. Arbitration resumes in the cycle res_ready rises, and a request accepted that cycle replaces the result.

## Test plan
- Reset, then idle: all outputs 0, req_ready 0 for 10 cycles. Assert reset mid-stall with res_valid=1 -> res_valid 0 on next edge, op_count 0.
- Requester 0 only, opa0=0_0011_10000000, opb0=0_0011_10000000 -> one cycle later res=0_0100_10000000, res_id=0, op_count=1.
- Requester 1 only, opa1=0_0101_11000000, opb1=1_0101_10000000 -> res=0_0011_10000000, res_id=1.
- Both valid continuously for 8 cycles with res_ready=1 -> res_id sequence 0,1,0,1,0,1,0,1; op_count=8.
- Both valid with res_ready=0 for 5 cycles after the first grant -> req_ready=00, res stable for those cycles. When res_ready rises, requester 1 is granted in that same cycle.
- Force op_count to 0xFFFF via 65535 accepts, then one more accept -> op_count=0x0000. Random constrained traffic checked against the golden model with zero mismatches.

Source files
------------

// File: rtl/fp_add_arb.sv
// fp_add_arb: two-requester round-robin front end for one shared
// combinational 13-bit float adder {sign, exp[3:0], frac[7:0]}.
// Accepted operand pairs are summed in the grant cycle and captured in a
// single-entry, ID-tagged result register with downstream backpressure.
//
// Handshake: a request on port i transfers on a rising edge where
// req_valid[i] && req_ready[i]; a result transfers on a rising edge where
// res_valid && res_ready. req_ready is combinational from req_valid, so
// requesters must not derive req_valid from req_ready, and must hold their
// operands stable while valid && !ready.
module fp_add_arb #(
    parameter int unsigned PRIO_FIRST = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [12:0] opa0,
    input  logic [12:0] opb0,
    input  logic [12:0] opa1,
    input  logic [12:0] opb1,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [12:0] res,
    output logic        res_id,
    output logic [15:0] op_count
);

    // last_gnt starts on the other requester so PRIO_FIRST wins the first tie
    localparam logic LAST_GNT_INIT = (PRIO_FIRST == 0) ? 1'b1 : 1'b0;

    logic        last_gnt;
    logic        slot_free;
    logic [1:0]  gnt;

    logic [12:0] op_a;
    logic [12:0] op_b;

    logic [12:0] big;
    logic [12:0] sml;
    logic [3:0]  exp_diff;
    logic [7:0]  sml_frac;
    logic [8:0]  sum;
    logic [3:0]  lzc;
    logic [8:0]  norm;
    logic        core_sign;
    logic [3:0]  core_exp;
    logic [7:0]  core_frac;

    // The result register can take a new sum when empty or being drained
    assign slot_free = !res_valid || res_ready;

    // Round-robin grant; nothing is granted during reset or while stalled
    always_comb begin
        gnt = 2'b00;
        if (!reset && slot_free) begin
            case (req_valid)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    assign req_ready = gnt;

    // Steer the granted requester's operands into the shared adder
    always_comb begin
        if (gnt[1]) begin
            op_a = opa1;
            op_b = opb1;
        end else begin
            op_a = opa0;
            op_b = opb0;
        end
    end

    // Order operands by magnitude (ties make op_b the larger) and align
    always_comb begin
        if (op_a[11:0] > op_b[11:0]) begin
            big = op_a;
            sml = op_b;
        end else begin
            big = op_b;
            sml = op_a;
        end
        exp_diff = big[11:8] - sml[11:8];
        sml_frac = sml[7:0] >> exp_diff;
    end

    // Effective add or subtract on the 9-bit fraction datapath
    always_comb begin
        if (big[12] == sml[12]) begin
            sum = {1'b0, big[7:0]} + {1'b0, sml_frac};
        end else begin
            sum = {1'b0, big[7:0]} - {1'b0, sml_frac};
        end
    end

    // Leading-zero count over the 9-bit sum; an all-zero sum counts as 9
    always_comb begin
        casez (sum)
            9'b1????????: lzc = 4'd0;
            9'b01???????: lzc = 4'd1;
            9'b001??????: lzc = 4'd2;
            9'b0001?????: lzc = 4'd3;
            9'b00001????: lzc = 4'd4;
            9'b000001???: lzc = 4'd5;
            9'b0000001??: lzc = 4'd6;
            9'b00000001?: lzc = 4'd7;
            9'b000000001: lzc = 4'd8;
            default:      lzc = 4'd9;
        endcase
    end

    // Carry bumps the exponent; otherwise normalise or flush to zero
    always_comb begin
        norm      = sum << lzc;
        core_sign = big[12];
        core_exp  = 4'd0;
        core_frac = 8'd0;
        if (sum[8]) begin
            core_exp  = big[11:8] + 4'd1;
            core_frac = sum[8:1];
        end else if (lzc > big[11:8]) begin
            core_exp  = 4'd0;
            core_frac = 8'd0;
        end else begin
            core_exp  = big[11:8] - lzc;
            core_frac = norm[8:1];
        end
    end

    // Result register, round-robin history and accept counter
    always_ff @(posedge clk) begin
        if (reset) begin
            res_valid <= 1'b0;
            res       <= 13'd0;
            res_id    <= 1'b0;
            op_count  <= 16'd0;
            last_gnt  <= LAST_GNT_INIT;
        end else begin
            if (gnt != 2'b00) begin
                res_valid <= 1'b1;
                res       <= {core_sign, core_exp, core_frac};
                res_id    <= gnt[1];
                last_gnt  <= gnt[1];
                op_count  <= op_count + 16'd1;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fp_add_arb.sv
// tb_fp_add_arb: directed vector table, hand-written arbitration and stall
// sequences, randomized traffic against a queue-based reference model, and
// the 16-bit accept counter wrap.
module tb_fp_add_arb;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [12:0] opa0, opb0, opa1, opb1;
    logic        res_valid;
    logic        res_ready;
    logic [12:0] res;
    logic        res_id;
    logic [15:0] op_count;

    int n_vec = 0;
    int n_err = 0;

    fp_add_arb #(.PRIO_FIRST(0)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .opa0      (opa0),
        .opb0      (opb0),
        .opa1      (opa1),
        .opb1      (opb1),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res       (res),
        .res_id    (res_id),
        .op_count  (op_count)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- compare helper ----------------
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference adder, plain integer arithmetic ----------------
    function automatic logic [12:0] fp_model(input logic [12:0] a, input logic [12:0] b);
        int ma, mb, el, es, fl, fsm, s, k, e, f;
        logic sl;
        ma = int'(a[11:8]) * 256 + int'(a[7:0]);
        mb = int'(b[11:8]) * 256 + int'(b[7:0]);
        if (ma > mb) begin
            sl = a[12]; el = int'(a[11:8]); fl = int'(a[7:0]);
            es = int'(b[11:8]); fsm = int'(b[7:0]);
        end else begin
            sl = b[12]; el = int'(b[11:8]); fl = int'(b[7:0]);
            es = int'(a[11:8]); fsm = int'(a[7:0]);
        end
        fsm = fsm >> (el - es);
        if (a[12] == b[12]) s = fl + fsm;
        else                s = fl - fsm;
        s = s & 511;
        if (s >= 256) begin
            e = (el + 1) % 16;
            f = (s >> 1) & 255;
        end else begin
            k = 0;
            while (k < 9 && (s << k) < 256) k++;
            if (k > el) begin
                e = 0;
                f = 0;
            end else begin
                e = el - k;
                f = ((s << k) >> 1) & 255;
            end
        end
        return {sl, 4'(e), 8'(f)};
    endfunction

    // ---------------- scoreboard / protocol monitor ----------------
    // exp_q holds {id, sum} for every accepted request not yet consumed;
    // its occupancy is the expected res_valid.
    logic [13:0] exp_q[$];
    logic        m_last;
    logic [15:0] m_count;

    always @(negedge clk) begin
        logic       exp_valid;
        logic       free;
        logic [1:0] eg;
        logic [12:0] pa, pb;
        if (reset) begin
            chk("reset_req_ready", 16'(req_ready), 16'd0);
            exp_q.delete();
            m_last  = 1'b1;
            m_count = 16'd0;
        end else begin
            exp_valid = (exp_q.size() != 0);
            chk("sb_res_valid", 16'(res_valid), 16'(exp_valid));
            if (exp_valid) begin
                chk("sb_res", 16'(res), 16'(exp_q[0][12:0]));
                chk("sb_res_id", 16'(res_id), 16'(exp_q[0][13]));
            end
            chk("sb_op_count", op_count, m_count);
            free = !exp_valid || res_ready;
            eg = 2'b00;
            if (free) begin
                if (req_valid == 2'b11)      eg = (m_last == 1'b0) ? 2'b10 : 2'b01;
                else                          eg = req_valid;
            end
            chk("sb_req_ready", 16'(req_ready), 16'(eg));
            if (exp_valid && res_ready) void'(exp_q.pop_front());
            if (eg != 2'b00) begin
                pa = eg[1] ? opa1 : opa0;
                pb = eg[1] ? opb1 : opb0;
                exp_q.push_back({eg[1], fp_model(pa, pb)});
                m_last  = eg[1];
                m_count = m_count + 16'd1;
            end
        end
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [12:0] a;
        logic [12:0] b;
        logic [12:0] exp_res;
    } vec_t;

    vec_t vt[10];

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [1:0]  g;
        logic [12:0] held;
        logic [1:0]  pend;
        logic [1:0]  acc;

        vt[0] = '{{1'b0, 4'd3, 8'h80},  {1'b0, 4'd3, 8'h80},  {1'b0, 4'd4, 8'h80}};
        vt[1] = '{{1'b0, 4'd5, 8'hC0},  {1'b1, 4'd5, 8'h80},  {1'b0, 4'd3, 8'h80}};
        vt[2] = '{{1'b0, 4'd4, 8'h80},  {1'b0, 4'd2, 8'h80},  {1'b0, 4'd3, 8'hA0}};
        vt[3] = '{{1'b0, 4'd6, 8'h80},  {1'b1, 4'd6, 8'h80},  {1'b1, 4'd0, 8'h00}};
        vt[4] = '{{1'b0, 4'd1, 8'h04},  {1'b0, 4'd1, 8'h01},  {1'b0, 4'd0, 8'h00}};
        vt[5] = '{{1'b0, 4'd12, 8'h10}, {1'b1, 4'd12, 8'h10}, {1'b1, 4'd3, 8'h00}};
        vt[6] = '{{1'b1, 4'd2, 8'h40},  {1'b1, 4'd2, 8'h40},  {1'b1, 4'd1, 8'h80}};
        vt[7] = '{{1'b0, 4'd15, 8'h01}, {1'b0, 4'd0, 8'hFF},  {1'b0, 4'd7, 8'h80}};
        vt[8] = '{{1'b0, 4'd15, 8'hFF}, {1'b0, 4'd15, 8'hFF}, {1'b0, 4'd0, 8'hFF}};
        vt[9] = '{{1'b0, 4'd5, 8'h01},  {1'b1, 4'd4, 8'hFF},  {1'b0, 4'd6, 8'hC1}};

        reset = 1'b1;
        req_valid = 2'b00;
        res_ready = 1'b1;
        opa0 = '0; opb0 = '0; opa1 = '0; opb1 = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // reset values and idle
        @(negedge clk);
        chk("rst_res_valid", 16'(res_valid), 16'd0);
        chk("rst_res", 16'(res), 16'd0);
        chk("rst_res_id", 16'(res_id), 16'd0);
        chk("rst_op_count", op_count, 16'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_req_ready", 16'(req_ready), 16'd0);
            chk("idle_res", 16'(res), 16'd0);
        end

        // table: even entries via requester 0, odd via requester 1
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (i % 2 == 0) begin
                opa0 = vt[i].a; opb0 = vt[i].b; req_valid = 2'b01;
            end else begin
                opa1 = vt[i].a; opb1 = vt[i].b; req_valid = 2'b10;
            end
            @(negedge clk);
            chk("vec_req_ready", 16'(req_ready), (i % 2 == 0) ? 16'd1 : 16'd2);
            @(posedge clk); #1;
            req_valid = 2'b00;
            @(negedge clk);
            chk("vec_res_valid", 16'(res_valid), 16'd1);
            chk("vec_res", 16'(res), 16'(vt[i].exp_res));
            chk("vec_res_id", 16'(res_id), 16'(i % 2));
            if (i == 0) chk("vec_first_count", op_count, 16'd1);
        end
        chk("vec_op_count", op_count, 16'd10);

        // both requesters valid: strict alternation from reset
        do_reset();
        req_valid = 2'b11;
        res_ready = 1'b1;
        opa0 = 13'($urandom); opb0 = 13'($urandom);
        opa1 = 13'($urandom); opb1 = 13'($urandom);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            g = req_ready;
            if (k > 0) chk("alt_res_id", 16'(res_id), 16'((k - 1) % 2));
            @(posedge clk); #1;
            if (k == 7) req_valid = 2'b00;
            else if (g[0]) begin opa0 = 13'($urandom); opb0 = 13'($urandom); end
            else if (g[1]) begin opa1 = 13'($urandom); opb1 = 13'($urandom); end
        end
        @(negedge clk);
        chk("alt_last_id", 16'(res_id), 16'd1);
        chk("alt_op_count", op_count, 16'd8);

        // stall with both valid, then resume granting requester 1
        do_reset();
        req_valid = 2'b11;
        res_ready = 1'b1;
        @(negedge clk);
        chk("stall_first_gnt", 16'(req_ready), 16'd1);
        @(posedge clk); #1;
        res_ready = 1'b0;
        @(negedge clk);
        held = res;
        for (int j = 0; j < 5; j++) begin
            if (j > 0) @(negedge clk);
            chk("stall_req_ready", 16'(req_ready), 16'd0);
            chk("stall_res_valid", 16'(res_valid), 16'd1);
            chk("stall_res_hold", 16'(res), 16'(held));
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(negedge clk);
        chk("resume_gnt", 16'(req_ready), 16'd2);
        @(posedge clk); #1;
        req_valid = 2'b00;
        res_ready = 1'b0;
        @(negedge clk);
        chk("resume_res_id", 16'(res_id), 16'd1);

        // reset while a result is pending and requests are presented
        @(posedge clk); #1;
        reset = 1'b1;
        req_valid = 2'b11;
        @(negedge clk);
        chk("rstmid_req_ready", 16'(req_ready), 16'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        req_valid = 2'b00;
        res_ready = 1'b1;
        @(negedge clk);
        chk("rstmid_res_valid", 16'(res_valid), 16'd0);
        chk("rstmid_op_count", op_count, 16'd0);

        // randomized traffic, scoreboard does the checking
        pend = 2'b00;
        acc = 2'b00;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (acc[i]) pend[i] = 1'b0;
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    if (i == 0) begin opa0 = 13'($urandom); opb0 = 13'($urandom); end
                    else        begin opa1 = 13'($urandom); opb1 = 13'($urandom); end
                end
            end
            req_valid = pend;
            res_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = req_ready;
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        res_ready = 1'b1;

        // accept counter wrap
        do_reset();
        req_valid = 2'b01;
        res_ready = 1'b1;
        repeat (65535) @(posedge clk);
        #1 req_valid = 2'b00;
        @(negedge clk);
        chk("wrap_ffff", op_count, 16'hFFFF);
        @(posedge clk); #1;
        req_valid = 2'b01;
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        chk("wrap_zero", op_count, 16'h0000);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
